// File: rtl/alu_dec_if.sv
// Valid/ready handshake bundle between an instruction source, the ALU
// function decoder and the downstream ALU mux.
interface alu_dec_if;
  logic       in_valid;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [8:0] fnct_sel;
  logic       illegal;
  logic [7:0] illegal_cnt;

  modport master (
    output in_valid, opcode, funct3, funct7, out_ready,
    input  in_ready, out_valid, fnct_sel, illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, opcode, funct3, funct7, out_ready,
    output in_ready, out_valid, fnct_sel, illegal, illegal_cnt
  );
endinterface

// File: rtl/alu_dec.sv
// ALU function decoder: R/I-type opcode/funct3/funct7 -> 9-bit mux select, one-cycle latency.
// Define ALU_DEC_SKID_EN to add a one-entry skid buffer with a registered in_ready.
module alu_dec (
  input  logic      clk,
  input  logic      reset,
  alu_dec_if.slave  bus
);

  localparam logic [8:0] SEL_ADD = 9'h000;
  localparam logic [8:0] SEL_SUB = 9'h040;
  localparam logic [8:0] SEL_AND = 9'h041;
  localparam logic [8:0] SEL_OR  = 9'h080;
  localparam logic [8:0] SEL_XOR = 9'h081;
  localparam logic [8:0] SEL_SLL = 9'h082;
  localparam logic [8:0] SEL_SRL = 9'h083;
  localparam logic [8:0] SEL_SLT = 9'h084;
  localparam logic [8:0] SEL_NOP = 9'h100;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Operation selected by funct3 alone; returns {bad, sel}.
  function automatic logic [9:0] base_op(input logic [2:0] funct3);
    logic [9:0] res;
    case (funct3)
      3'b000:  res = {1'b0, SEL_ADD};
      3'b001:  res = {1'b0, SEL_SLL};
      3'b010:  res = {1'b0, SEL_SLT};
      3'b100:  res = {1'b0, SEL_XOR};
      3'b101:  res = {1'b0, SEL_SRL};
      3'b110:  res = {1'b0, SEL_OR};
      3'b111:  res = {1'b0, SEL_AND};
      default: res = {1'b1, SEL_NOP};
    endcase
    return res;
  endfunction

  // Full decode; returns {illegal, fnct_sel}.
  function automatic logic [9:0] decode(input logic [6:0] opcode,
                                        input logic [2:0] funct3,
                                        input logic [6:0] funct7);
    logic [9:0] res;
    logic       is_shift;
    is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    case (opcode)
      OP_R: begin
        if (funct7 == F7_ZERO) begin
          res = base_op(funct3);
        end else if ((funct7 == F7_ALT) && (funct3 == 3'b000)) begin
          res = {1'b0, SEL_SUB};
        end else begin
          res = {1'b1, SEL_NOP};
        end
      end
      OP_I: begin
        // Immediate shifts reuse funct7 as the upper shamt field; only the logical forms are legal.
        if (is_shift && (funct7 != F7_ZERO)) begin
          res = {1'b1, SEL_NOP};
        end else begin
          res = base_op(funct3);
        end
      end
      default: res = {1'b1, SEL_NOP};
    endcase
    return res;
  endfunction

  logic [8:0] dec_sel_s;
  logic       dec_illegal_s;
  logic       in_ready_s;
  logic       in_fire_s;
  logic       out_adv_s;

  logic       out_valid_r;
  logic [8:0] fnct_sel_r;
  logic       illegal_r;
  logic [7:0] illegal_cnt_r;

  assign {dec_illegal_s, dec_sel_s} = decode(bus.opcode, bus.funct3, bus.funct7);

  assign out_adv_s = !out_valid_r || bus.out_ready;
  assign in_fire_s = bus.in_valid && in_ready_s;

  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_r;
  assign bus.fnct_sel    = fnct_sel_r;
  assign bus.illegal     = illegal_r;
  assign bus.illegal_cnt = illegal_cnt_r;

`ifdef ALU_DEC_SKID_EN
  logic       skid_valid_r;
  logic [8:0] skid_sel_r;
  logic       skid_illegal_r;
  logic       in_ready_r;

  assign in_ready_s = in_ready_r;

  // Output register fed from the skid entry first, else straight from the decoder.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r    <= 1'b0;
      fnct_sel_r     <= SEL_NOP;
      illegal_r      <= 1'b0;
      skid_valid_r   <= 1'b0;
      skid_sel_r     <= SEL_NOP;
      skid_illegal_r <= 1'b0;
      in_ready_r     <= 1'b0;
    end else if (out_adv_s) begin
      // in_ready_r is low whenever the skid is full, so no new op competes with it here.
      if (skid_valid_r) begin
        out_valid_r    <= 1'b1;
        fnct_sel_r     <= skid_sel_r;
        illegal_r      <= skid_illegal_r;
        skid_valid_r   <= 1'b0;
        skid_sel_r     <= SEL_NOP;
        skid_illegal_r <= 1'b0;
      end else if (in_fire_s) begin
        out_valid_r <= 1'b1;
        fnct_sel_r  <= dec_sel_s;
        illegal_r   <= dec_illegal_s;
      end else begin
        out_valid_r <= 1'b0;
        fnct_sel_r  <= SEL_NOP;
        illegal_r   <= 1'b0;
      end
      in_ready_r <= 1'b1;
    end else if (in_fire_s) begin
      skid_valid_r   <= 1'b1;
      skid_sel_r     <= dec_sel_s;
      skid_illegal_r <= dec_illegal_s;
      in_ready_r     <= 1'b0;
    end else begin
      in_ready_r <= !skid_valid_r;
    end
  end
`else
  logic ready_en_r;

  assign in_ready_s = ready_en_r && out_adv_s;

  // Holds in_ready low until the first edge after reset releases.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // Single output stage; drained slots return to the idle NOP encoding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      fnct_sel_r  <= SEL_NOP;
      illegal_r   <= 1'b0;
    end else if (in_fire_s) begin
      out_valid_r <= 1'b1;
      fnct_sel_r  <= dec_sel_s;
      illegal_r   <= dec_illegal_s;
    end else if (bus.out_ready) begin
      out_valid_r <= 1'b0;
      fnct_sel_r  <= SEL_NOP;
      illegal_r   <= 1'b0;
    end
  end
`endif

  // Saturating count of accepted illegal ops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal_cnt_r <= 8'h00;
    end else if (in_fire_s && dec_illegal_s && (illegal_cnt_r != 8'hFF)) begin
      illegal_cnt_r <= illegal_cnt_r + 8'h01;
    end
  end

endmodule

// File: tb/tb_alu_dec.sv
// Self-checking bench for alu_dec: directed scenarios plus a randomized stream
// scored against a queue-based reference model.
module tb_alu_dec;

`ifdef ALU_DEC_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  localparam logic [8:0] T_ADD = 9'h000;
  localparam logic [8:0] T_SUB = 9'h040;
  localparam logic [8:0] T_AND = 9'h041;
  localparam logic [8:0] T_OR  = 9'h080;
  localparam logic [8:0] T_XOR = 9'h081;
  localparam logic [8:0] T_SLL = 9'h082;
  localparam logic [8:0] T_SRL = 9'h083;
  localparam logic [8:0] T_SLT = 9'h084;
  localparam logic [8:0] T_NOP = 9'h100;
  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;

  logic clk;
  logic reset;
  alu_dec_if bus ();

  alu_dec dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;

  // Reference model state: ops accepted but not yet drained, in order.
  logic [9:0] exp_q[$];
  int         exp_cnt;
  bit         ready_ok;
  bit         last_accept;

  // Reference decode from a funct3-indexed table; returns {illegal, sel}.
  function automatic logic [9:0] ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                            input logic [6:0] f7);
    logic [8:0] by_f3 [0:7];
    bit         f3_ok;
    by_f3 = '{T_ADD, T_SLL, T_SLT, T_NOP, T_XOR, T_SRL, T_OR, T_AND};
    f3_ok = (f3 != 3'd3);
    if (op == R_OP && f7 == 7'd0 && f3_ok)             return {1'b0, by_f3[f3]};
    if (op == R_OP && f7 == 7'h20 && f3 == 3'd0)       return {1'b0, T_SUB};
    if (op == I_OP && f3_ok && (f3 == 3'd1 || f3 == 3'd5) && f7 != 7'd0) return {1'b1, T_NOP};
    if (op == I_OP && f3_ok)                           return {1'b0, by_f3[f3]};
    return {1'b1, T_NOP};
  endfunction

  function automatic bit exp_ready();
    if (!ready_ok) return 1'b0;
    if (SKID) return exp_q.size() < 2;
    return (exp_q.size() == 0) || bus.out_ready;
  endfunction

  // Advance one clock from a negedge to the next, updating the model.
  task automatic tick();
    bit acc;
    bit drn;
    #1;
    acc = bus.in_valid && exp_ready() && !reset;
    drn = (exp_q.size() != 0) && bus.out_ready && !reset;
    @(posedge clk);
    if (!reset) begin
      if (drn) void'(exp_q.pop_front());
      if (acc) begin
        exp_q.push_back(ref_decode(bus.opcode, bus.funct3, bus.funct7));
        if (ref_decode(bus.opcode, bus.funct3, bus.funct7) >= 10'h200 && exp_cnt < 255) exp_cnt++;
      end
      ready_ok = 1'b1;
    end
    last_accept = acc;
    @(negedge clk);
  endtask

  task automatic set_op(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_cnt  = 0;
    ready_ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    set_op(7'd0, 3'd0, 7'd0);
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.fnct_sel !== T_NOP) begin errors++; $display("FAIL reset_fnct_sel got=%h exp=%h", bus.fnct_sel, T_NOP); end
    checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b exp=0", bus.illegal); end
    checks++; if (bus.illegal_cnt !== 8'h00) begin errors++; $display("FAIL reset_cnt got=%h exp=00", bus.illegal_cnt); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    reset = 1'b0;
    tick();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", bus.in_ready); end
  endtask

  task automatic test_rtype();
    logic [2:0] f3s [0:7];
    logic [6:0] f7s [0:7];
    logic [8:0] sels [0:7];
    f3s  = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b100, 3'b001, 3'b101, 3'b010};
    f7s  = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
    sels = '{T_ADD, T_SUB, T_AND, T_OR, T_XOR, T_SLL, T_SRL, T_SLT};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      set_op(R_OP, f3s[i], f7s[i]);
      #1;
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rtype_in_ready op=%0d got=%b exp=1", i, bus.in_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.fnct_sel !== sels[i] || bus.illegal !== 1'b0)
        begin errors++; $display("FAIL rtype_out op=%0d got=%b/%h/%b exp=1/%h/0", i, bus.out_valid, bus.fnct_sel, bus.illegal, sels[i]); end
    end
    bus.in_valid = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.fnct_sel !== T_NOP || bus.illegal !== 1'b0)
      begin errors++; $display("FAIL rtype_idle got=%b/%h/%b exp=0/100/0", bus.out_valid, bus.fnct_sel, bus.illegal); end
  endtask

  task automatic test_itype();
    int cnt_before;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    set_op(I_OP, 3'b000, 7'b0100000);
    tick();
    checks++; if (bus.fnct_sel !== T_ADD || bus.illegal !== 1'b0)
      begin errors++; $display("FAIL itype_add got=%h/%b exp=000/0", bus.fnct_sel, bus.illegal); end
    cnt_before = exp_cnt;
    set_op(I_OP, 3'b001, 7'b0100000);
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.fnct_sel !== T_NOP || bus.illegal !== 1'b1 || bus.out_valid !== 1'b1)
      begin errors++; $display("FAIL itype_sll_bad got=%b/%h/%b exp=1/100/1", bus.out_valid, bus.fnct_sel, bus.illegal); end
    checks++; if (bus.illegal_cnt !== 8'(cnt_before + 1))
      begin errors++; $display("FAIL itype_cnt got=%0d exp=%0d", bus.illegal_cnt, cnt_before + 1); end
    tick();
  endtask

  task automatic test_backpressure();
    bit or_taken;
    bit rdy_exp;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    set_op(R_OP, 3'b100, 7'h00);
    tick();
    or_taken = 1'b0;
    set_op(R_OP, 3'b110, 7'h00);
    for (int k = 0; k < 3; k++) begin
      bus.out_ready = 1'b0;
      bus.in_valid = !or_taken;
      #1;
      rdy_exp = SKID && (k == 0);
      checks++; if (bus.in_ready !== rdy_exp)
        begin errors++; $display("FAIL bp_in_ready k=%0d got=%b exp=%b", k, bus.in_ready, rdy_exp); end
      tick();
      if (last_accept) or_taken = 1'b1;
      checks++; if (bus.out_valid !== 1'b1 || bus.fnct_sel !== T_XOR)
        begin errors++; $display("FAIL bp_hold k=%0d got=%b/%h exp=1/081", k, bus.out_valid, bus.fnct_sel); end
    end
    bus.out_ready = 1'b1;
    bus.in_valid = !or_taken;
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.fnct_sel !== T_OR)
      begin errors++; $display("FAIL bp_or got=%b/%h exp=1/080", bus.out_valid, bus.fnct_sel); end
    tick();
    checks++; if (bus.out_valid !== 1'b0 || bus.fnct_sel !== T_NOP)
      begin errors++; $display("FAIL bp_no_dup got=%b/%h exp=0/100", bus.out_valid, bus.fnct_sel); end
  endtask

  task automatic test_random();
    logic [9:0] exp_o;
    bit         exp_v;
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 2))
        0:       bus.opcode = R_OP;
        1:       bus.opcode = I_OP;
        default: bus.opcode = 7'($urandom);
      endcase
      bus.funct3 = 3'($urandom);
      case ($urandom_range(0, 2))
        0:       bus.funct7 = 7'h00;
        1:       bus.funct7 = 7'h20;
        default: bus.funct7 = 7'($urandom);
      endcase
      #1;
      checks++; if (bus.in_ready !== exp_ready())
        begin errors++; $display("FAIL rand_in_ready cyc=%0d got=%b exp=%b", i, bus.in_ready, exp_ready()); end
      tick();
      exp_v = (exp_q.size() != 0);
      exp_o = exp_v ? exp_q[0] : {1'b0, T_NOP};
      checks++; if (bus.out_valid !== exp_v)
        begin errors++; $display("FAIL rand_out_valid cyc=%0d got=%b exp=%b", i, bus.out_valid, exp_v); end
      checks++; if ({bus.illegal, bus.fnct_sel} !== exp_o)
        begin errors++; $display("FAIL rand_out cyc=%0d got=%b/%h exp=%b/%h", i, bus.illegal, bus.fnct_sel, exp_o[9], exp_o[8:0]); end
      checks++; if (bus.illegal_cnt !== 8'(exp_cnt))
        begin errors++; $display("FAIL rand_cnt cyc=%0d got=%0d exp=%0d", i, bus.illegal_cnt, exp_cnt); end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_saturate();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    set_op(7'h00, 3'd0, 7'd0);
    repeat (300) tick();
    checks++; if (bus.illegal_cnt !== 8'hFF || exp_cnt != 255)
      begin errors++; $display("FAIL sat_cnt got=%h exp=ff model=%0d", bus.illegal_cnt, exp_cnt); end
    repeat (5) tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.illegal_cnt !== 8'hFF)
      begin errors++; $display("FAIL sat_hold got=%h exp=ff", bus.illegal_cnt); end
    repeat (2) tick();
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    set_op(R_OP, 3'b000, 7'h20);
    tick();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.fnct_sel !== T_SUB)
      begin errors++; $display("FAIL ar_setup got=%b/%h exp=1/040", bus.out_valid, bus.fnct_sel); end
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.fnct_sel !== T_NOP || bus.illegal_cnt !== 8'h00 || bus.in_ready !== 1'b0)
      begin errors++; $display("FAIL ar_immediate got=%b/%h/%h/%b exp=0/100/00/0", bus.out_valid, bus.fnct_sel, bus.illegal_cnt, bus.in_ready); end
    @(negedge clk);
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.out_valid !== 1'b0 || bus.fnct_sel !== T_NOP)
        begin errors++; $display("FAIL ar_discard cyc=%0d got=%b/%h exp=0/100", i, bus.out_valid, bus.fnct_sel); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    errors = 0;
    checks = 0;
    last_accept = 1'b0;
    test_reset();
    test_rtype();
    test_itype();
    test_backpressure();
    test_random();
    test_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_dec.md
ALU_DEC -- requirements
Module: alu_dec

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  asynchronous active-high reset.
REQ-002 Inputs SHALL be: in_valid 1 (operation offered); opcode 7; funct3 3; funct7 7 (instruction fields); out_ready 1 (downstream accepts).
REQ-003 Outputs SHALL be: in_ready 1 (block accepts); out_valid 1 (fnct_sel valid); fnct_sel 9 (ALU mux select); illegal 1 (current output from an undecodable op); illegal_cnt 8 (illegal ops accepted, saturating).

Function
REQ-004 fnct_sel encoding SHALL be: ADD 9'h000, SUB 9'h040, AND 9'h041, OR 9'h080, XOR 9'h081, SLL 9'h082, SRL 9'h083, SLT 9'h084, NOP 9'h100.
REQ-005 For R-type, opcode 7'b0110011, funct3/funct7 SHALL map: 000/0000000 ADD; 000/0100000 SUB; 111/0000000 AND; 110/0000000 OR; 100/0000000 XOR; 001/0000000 SLL; 101/0000000 SRL; 010/0000000 SLT.
REQ-006 For I-type, opcode 7'b0010011: 000 ADD, 111 AND, 110 OR, 100 XOR, 010 SLT with funct7 ignored; 001 SLL and 101 SRL only with funct7 = 0.
REQ-007 Any other combination SHALL decode to fnct_sel NOP with illegal = 1; legal ops SHALL set illegal = 0.
REQ-008 Transfer SHALL occur on a clk edge where valid and ready are both high, on each side independently.
REQ-009 Latency SHALL be exactly one cycle: an op accepted at edge N is presented with out_valid = 1 after edge N.
REQ-010 Once out_valid = 1, fnct_sel and illegal SHALL hold stable until the transfer completes.
REQ-011 Throughput SHALL be one op per cycle while out_ready stays high.
REQ-012 The decoder SHALL neither drop nor duplicate ops; output order SHALL equal acceptance order.
REQ-013 When out_valid = 0, fnct_sel SHALL be NOP and illegal SHALL be 0.
REQ-014 illegal_cnt SHALL increment by 1 on each accepted illegal op and saturate at 8'hFF.
REQ-015 in_valid with in_ready = 0 SHALL be ignored and SHALL NOT affect illegal_cnt.

Reset
REQ-016 reset SHALL immediately clear out_valid, illegal, illegal_cnt, and any buffered entry, and set fnct_sel to NOP, without waiting for clk.
REQ-017 in_ready SHALL be 0 while reset is high and 1 in the first cycle after reset deasserts.
REQ-018 An op in flight when reset asserts SHALL be discarded and never presented.

Configuration
REQ-019 Macro ALU_DEC_SKID_EN defined: a one-entry skid buffer SHALL be present; in_ready SHALL be a register output equal to "skid buffer empty".
REQ-020 In that mode, an op accepted while the output is stalled SHALL enter the skid buffer and SHALL move to the output on the first edge with out_ready = 1.
REQ-021 ALU_DEC_SKID_EN undefined: no skid buffer; in_ready SHALL be combinational, equal to !out_valid || out_ready.
REQ-022 Both builds SHALL meet REQ-009 to REQ-015.

Verification
REQ-023 Accept R-type ops ADD, SUB, AND, OR, XOR, SLL, SRL, SLT back-to-back with out_ready = 1 -> fnct_sel sequence 000, 040, 041, 080, 081, 082, 083, 084; each appears one cycle after acceptance; illegal = 0.
REQ-024 I-type funct3 = 000, funct7 = 0100000 -> ADD (9'h000); I-type funct3 = 001, funct7 = 0100000 -> NOP, illegal = 1, illegal_cnt increments.
REQ-025 Backpressure: hold out_ready = 0 for 3 cycles during a stream of XOR then OR -> XOR is held stable and OR is neither lost nor duplicated. With skid: in_ready falls one cycle after the stall begins. Without skid: in_ready falls in the same cycle.
REQ-026 Submit 300 illegal ops (opcode 7'h00) -> illegal_cnt = 8'hFF and stays there.
REQ-027 Assert reset asynchronously while out_valid = 1 with out_ready = 0 -> out_valid = 0, fnct_sel = 9'h100, illegal_cnt = 0 before the next clk edge; the held op is never presented afterwards.
